// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer; slot 0 is always the head.
module fetch_buf
  import cpu_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  logic         v0_q, v0_d, v1_q, v1_d;
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;

  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    e0_d = e0_q;
    e1_d = e1_q;
    if (pop && v0_q) begin
      v0_d = v1_q;
      e0_d = e1_q;
      v1_d = 1'b0;
    end
    // Push lands in the first free slot after any pop has shifted the queue.
    if (push) begin
      if (!v0_d) begin
        e0_d = din;
        v0_d = 1'b1;
      end else begin
        e1_d = din;
        v1_d = 1'b1;
      end
    end
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end

  assign count      = {1'b0, v0_q} + {1'b0, v1_q};
  assign head_valid = v0_q;
  assign head       = e0_q;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: request/ack memory interface feeding a 2-entry buffer,
// with redirect handling that discards in-flight data.
module ins_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic         xfer, buf_push, buf_pop, buf_valid;
  logic [1:0]   buf_count, cnt_after;
  logic [31:0]  tgt, nxt;
  fetch_entry_t buf_din, buf_head;

  assign xfer     = req_q & imem_ack;
  assign tgt      = align_pc(redirect_pc);
  assign nxt      = addr_q + PC_STEP;
  assign buf_push = (state_q == FETCH) & xfer & ~redirect_valid;
  assign buf_pop  = buf_valid & out_ready & ~redirect_valid;
  assign buf_din  = '{pc: addr_q, ins: imem_rdata};
  assign cnt_after = buf_count + {1'b0, buf_push} - {1'b0, buf_pop};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = redirect_valid ? tgt : pc_q;
        pc_d    = addr_d;
      end
      FETCH: begin
        if (redirect_valid && xfer) begin
          addr_d = tgt;
          pc_d   = tgt;
        end else if (redirect_valid) begin
          // Request is still outstanding; it must complete before the new one.
          state_d = DROP;
          pc_d    = tgt;
        end else if (xfer) begin
          pc_d   = nxt;
          addr_d = nxt;
          if (int'(cnt_after) < BUF_DEPTH) begin
            req_d = 1'b1;
          end else begin
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = tgt;
          pc_d    = tgt;
        end else if (buf_pop) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      DROP: begin
        if (xfer) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = redirect_valid ? tgt : pc_q;
          pc_d    = addr_d;
        end else if (redirect_valid) begin
          pc_d = tgt;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (buf_push),
    .pop        (buf_pop),
    .flush      (redirect_valid),
    .din        (buf_din),
    .count      (buf_count),
    .head_valid (buf_valid),
    .head       (buf_head)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = buf_valid;
  assign out_ins   = buf_head.ins;
  assign out_pc    = buf_head.pc;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a scoreboard-driven output monitor.
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Memory returns a word tagged with its own address.
  always_comb imem_rdata = {16'hC0DE, imem_addr[15:0]};

  ins_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ins        (out_ins),
    .out_pc         (out_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins);
    sb_q.push_back('{pc: pc, ins: ins});
  endtask

  // Monitor: every accepted output word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got pc=%h ins=%h expected no output", out_pc, out_ins);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_pc !== e.pc || out_ins !== e.ins) begin
          fails++;
          $display("FAIL out_word: got pc=%h ins=%h expected pc=%h ins=%h",
                   out_pc, out_ins, e.pc, e.ins);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    // Reset
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_ins", out_ins, 32'd0);
    rst_n = 1'b1;
    step();
    check("boot_req", {31'd0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, 32'd0);
    check("boot_valid", {31'd0, out_valid}, 32'd0);

    // Streaming
    out_ready = 1'b1;
    imem_ack = 1'b1;
    expect_out(32'h0, 32'hC0DE_0000);
    expect_out(32'h4, 32'hC0DE_0004);
    expect_out(32'h8, 32'hC0DE_0008);
    expect_out(32'hC, 32'hC0DE_000C);
    step();
    check("stream_pc0", out_pc, 32'h0);
    step();
    check("stream_pc4", out_pc, 32'h4);
    step();
    check("stream_pc8", out_pc, 32'h8);
    step();
    check("stream_pc12", out_pc, 32'hC);
    imem_ack = 1'b0;
    step();
    check("stream_empty", {31'd0, out_valid}, 32'd0);
    check("stream_next_addr", imem_addr, 32'h10);

    // Redirect with the 0x10 request still outstanding
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("drop_req_held", {31'd0, imem_req}, 32'd1);
    check("drop_addr_held", imem_addr, 32'h10);
    imem_ack = 1'b1;
    step();
    check("drop_new_addr", imem_addr, 32'h200);
    check("drop_no_out", {31'd0, out_valid}, 32'd0);
    expect_out(32'h200, 32'hC0DE_0200);
    step();
    imem_ack = 1'b0;
    step();
    check("drop_drained", {31'd0, out_valid}, 32'd0);

    // Reset while a request is pending, stray ack after release
    check("pend_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    step();
    check("midrst_restart_addr", imem_addr, 32'h0);
    check("midrst_ack_ignored", {31'd0, out_valid}, 32'd0);

    // Backpressure: two words buffered, then HOLD
    expect_out(32'h0, 32'hC0DE_0000);
    expect_out(32'h4, 32'hC0DE_0004);
    step();
    step();
    check("bp_hold_req", {31'd0, imem_req}, 32'd0);
    check("bp_head_pc", out_pc, 32'h0);
    step();
    check("bp_still_hold", {31'd0, imem_req}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    imem_ack = 1'b0;
    check("bp_resume_req", {31'd0, imem_req}, 32'd1);
    check("bp_resume_addr", imem_addr, 32'h8);
    check("bp_head_after_pop", out_pc, 32'h4);
    out_ready = 1'b1;
    step();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Wrap at the top of the address space via an unaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    imem_ack = 1'b1;
    step();
    check("wrap_target", imem_addr, 32'hFFFF_FFFC);
    expect_out(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0);
    imem_ack = 1'b0;
    step();

    // Redirect coinciding with ack: data discarded, no DROP
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    check("redir_ack_addr", imem_addr, 32'h300);
    check("redir_ack_req", {31'd0, imem_req}, 32'd1);
    check("redir_ack_no_out", {31'd0, out_valid}, 32'd0);
    step();
    step();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
